// File: rtl/cpu_pkg.sv
// Shared CPU constants and types used by the fetch stage and address checkers.
package cpu_pkg;

    localparam int unsigned CPU_AW = 32;

    localparam logic [CPU_AW-1:0] RESET_PC_DEF  = 32'h0000_3000;
    localparam logic [CPU_AW-1:0] EXC_PC_DEF    = 32'h0000_4180;
    localparam logic [CPU_AW-1:0] IMEM_BASE_DEF = 32'h0000_3000;
    localparam logic [CPU_AW-1:0] IMEM_SIZE_DEF = 32'h0000_4000;

    // RUN: sequential fetch; PEND: a redirect is waiting for the next advance
    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } pc_state_t;

endpackage

// File: rtl/pc_unit_if.sv
// Fetch-stage PC bundle: control requests in, fetch address and status out.
interface pc_unit_if #(
    parameter int unsigned AW = 32
);

    logic          stall;
    logic          imem_ready;
    logic          redir_valid;
    logic [AW-1:0] redir_target;
    logic          exc_req;
    logic          eret_req;
    logic [AW-1:0] epc;

    logic [AW-1:0] pc;
    logic [AW-1:0] pc_plus4;
    logic          pc_valid;
    logic          adel;
    logic          pend_valid;

    // Pipeline control / test side
    modport master (
        output stall, imem_ready, redir_valid, redir_target,
        output exc_req, eret_req, epc,
        input  pc, pc_plus4, pc_valid, adel, pend_valid
    );

    // PC unit side
    modport slave (
        input  stall, imem_ready, redir_valid, redir_target,
        input  exc_req, eret_req, epc,
        output pc, pc_plus4, pc_valid, adel, pend_valid
    );

endinterface

// File: rtl/pc_unit_range_chk.sv
// Combinational word-alignment and address-window check; shared with the D-memory path.
module pc_range_chk #(
    parameter int unsigned      AW   = 32,
    parameter logic [AW-1:0]    BASE = '0,
    parameter logic [AW-1:0]    SIZE = '0
) (
    input  logic          valid_i,
    input  logic [AW-1:0] addr_i,
    output logic          adel_c_o
);

    // One extra bit so a window ending exactly at 2^AW stays representable
    localparam logic [AW:0] LIMIT = {1'b0, BASE} + {1'b0, SIZE};

    logic misalign;
    logic below;
    logic above;

    always_comb begin
        misalign = (addr_i[1:0] != 2'b00);
        below    = (addr_i < BASE);
        above    = ({1'b0, addr_i} >= LIMIT);
        adel_c_o = valid_i & (misalign | below | above);
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter with stall, imem handshake, buffered redirect and exception/ERET entry.
module pc_unit
    import cpu_pkg::*;
#(
    parameter int unsigned   AW        = 32,
    parameter logic [AW-1:0] RESET_PC  = AW'(RESET_PC_DEF),
    parameter logic [AW-1:0] EXC_PC    = AW'(EXC_PC_DEF),
    parameter logic [AW-1:0] IMEM_BASE = AW'(IMEM_BASE_DEF),
    parameter logic [AW-1:0] IMEM_SIZE = AW'(IMEM_SIZE_DEF)
) (
    input  logic     clk,
    input  logic     rst,
    pc_unit_if.slave bus
);

    localparam logic [AW-1:0] PC_STEP = AW'(4);

    pc_state_t     state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] pc_plus4_q;
    logic [AW-1:0] pend_target_q, pend_target_d;
    logic          pc_valid_q;
    logic          advance;
    logic          adel_c;

    assign advance = bus.imem_ready & ~bus.stall;

    // Next-PC priority: exception > ERET > redirect > buffered redirect > sequential
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_target_d = pend_target_q;

        if (bus.exc_req) begin
            pc_d    = EXC_PC;
            state_d = RUN;
        end else if (bus.eret_req) begin
            pc_d    = bus.epc;
            state_d = RUN;
        end else if (bus.redir_valid) begin
            if (advance) begin
                pc_d    = bus.redir_target;
                state_d = RUN;
            end else begin
                // Newest target overwrites any older buffered one
                pend_target_d = bus.redir_target;
                state_d       = PEND;
            end
        end else if (advance) begin
            if (state_q == PEND) begin
                pc_d    = pend_target_q;
                state_d = RUN;
            end else begin
                pc_d = pc_q + PC_STEP;
            end
        end
    end

    // pc_plus4 is kept as its own register so the F/D fields come straight from flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            pc_plus4_q    <= RESET_PC + PC_STEP;
            pend_target_q <= '0;
            pc_valid_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pc_plus4_q    <= pc_d + PC_STEP;
            pend_target_q <= pend_target_d;
            pc_valid_q    <= 1'b1;
        end
    end

    pc_range_chk #(
        .AW   (AW),
        .BASE (IMEM_BASE),
        .SIZE (IMEM_SIZE)
    ) u_range_chk (
        .valid_i  (pc_valid_q),
        .addr_i   (pc_q),
        .adel_c_o (adel_c)
    );

    assign bus.pc         = pc_q;
    assign bus.pc_plus4   = pc_plus4_q;
    assign bus.pc_valid   = pc_valid_q;
    assign bus.pend_valid = (state_q == PEND);
    assign bus.adel       = adel_c;

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised fetch-stage program counter for the pipelined MIPS core. It replaces the single-register PC with one that supports:
- pipeline stall;
- an instruction-memory ready handshake;
- branch/jump redirect with a pending-redirect buffer;
- exception entry and ERET return;
- fetch-address error detection.

It sits in the F stage and drives the instruction-memory address and the F/D pipeline register's PC fields.

## Interface
Parameters:
- `AW`, 32: address width.
- `RESET_PC`, 32'h0000_3000: PC value loaded on reset.
- `EXC_PC`, 32'h0000_4180: exception handler entry.
- `IMEM_BASE`, 32'h0000_3000: lowest legal fetch address.
- `IMEM_SIZE`, 32'h0000_4000: legal fetch window size in bytes.

Ports (clock and reset first):
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `stall`, in, 1: hazard unit holds F/D; PC must not advance.
- `imem_ready`, in, 1: instruction memory accepts the current `pc` this cycle.
- `redir_valid`, in, 1: D stage resolved a taken branch/jump/jr.
- `redir_target`, in, AW: branch/jump target.
- `exc_req`, in, 1: M stage takes an exception or interrupt.
- `eret_req`, in, 1: M stage commits ERET.
- `epc`, in, AW: return address from CP0.
- `pc`, out, AW: current fetch address.
- `pc_plus4`, out, AW: `pc + 4`, wraps modulo 2^AW.
- `pc_valid`, out, 1: `pc` is a live fetch request.
- `adel`, out, 1: fetch address error on current `pc`.
- `pend_valid`, out, 1: a redirect is buffered (debug/verification visibility).

## Operation
- `advance = imem_ready & ~stall`.
- Priority for next PC, highest first:
  - `exc_req`: `pc <= EXC_PC`. Ignores `stall` and `imem_ready`. Clears the pending buffer.
  - `eret_req`: `pc <= epc`. Same override rules. Clears the pending buffer.
  - `redir_valid & advance`: `pc <= redir_target`. Pending buffer cleared.
  - `redir_valid & ~advance`: capture `redir_target` into the pending buffer and enter state PEND. `pc` holds.
  - PEND & `advance`: `pc <= pend_target`, return to RUN.
  - RUN & `advance`: `pc <= pc + 4`.
  - Otherwise: hold.
- State machine:
  - RUN → PEND on redirect without advance.
  - PEND → RUN on advance, `exc_req`, or `eret_req`.
  - PEND with a new `redir_valid` and no advance: buffer overwritten with the newest target.
- `adel = pc_valid & ((pc[1:0] != 0) | (pc < IMEM_BASE) | (pc >= IMEM_BASE + IMEM_SIZE))`. Combinational from registered `pc`. The PC continues to advance normally; the downstream CP0 handles the fault.
- `pc_valid` is 1 in every cycle after reset release.
- Range comparisons are unsigned, in AW bits. `IMEM_BASE + IMEM_SIZE` is computed in AW+1 bits so a window ending at 2^AW is legal.

## Timing
- Reset values: `pc = RESET_PC`, `pc_plus4 = RESET_PC + 4`, `pc_valid = 0` during `rst` (1 from the first cycle after), `adel = 0`, `pend_valid = 0`, state RUN.
- Redirect latency is 1 cycle: a request asserted in cycle n with `advance` gives `pc = target` in cycle n+1.
- Buffered redirect: `pc = target` in the cycle after the first cycle with `advance` high.
- `exc_req` or `eret_req` in cycle n gives the new `pc` in cycle n+1, even under `stall` or a low `imem_ready`.
- `exc_req` and `eret_req` together: `exc_req` wins.
- Exception together with a redirect: the redirect is dropped.
- `rst` overrides everything, including mid-PEND. The buffer is discarded.
- Address wrap: `pc = 2^AW - 4` advances to 0; `pc_plus4` wraps identically.

## Structure
- Shared package `cpu_pkg`: `RESET_PC`, `EXC_PC`, `IMEM_BASE`, `IMEM_SIZE` default constants, and the 1-bit state enum `pc_state_t {RUN, PEND}`.
- One natural sub-module, `pc_range_chk`: purely combinational alignment and window check producing `adel`. Reused later by the D-memory address check.
- The remainder is a single always block for the PC, state, and pending buffer, plus a next-PC priority mux.

## Test plan
- **Reset and sequential fetch:** hold `rst` 2 cycles, then run with `imem_ready = 1` → `pc` = 0x3000, 0x3004, 0x3008; `pc_valid` rises 1 cycle after `rst` falls; `adel = 0`.
- **Redirect with advance:** at `pc = 0x3008`, `redir_valid = 1`, `redir_target = 0x3100` → next `pc = 0x3100`, then 0x3104.
- **Redirect during stall:** `stall = 1` for 3 cycles with `redir_target = 0x3200` in the first → `pend_valid = 1`, `pc` held; first unstalled cycle → `pc = 0x3200`, `pend_valid = 0`.
- **Exception overrides:** `stall = 1`, `imem_ready = 0`, PEND holding 0x3300, `exc_req = 1` → next `pc = 0x4180`, `pend_valid = 0`. Then `eret_req = 1`, `epc = 0x3010` → `pc = 0x3010`.
- **Address error:** `redir_target = 0x3002` → `adel = 1`. `redir_target = 0x7000` → `adel = 1`. `redir_target = 0x6FFC` → `adel = 0`.
- **Simultaneous requests and reset mid-PEND:** `exc_req` with `eret_req` → `pc = 0x4180`. `rst` asserted while in PEND → `pc = 0x3000`, `pend_valid = 0`.
